// File: rtl/arith_sequencer_if.sv
// Decoder / PE-array facing bundle of the OP-V arithmetic sequencer.
// The slave modport is the sequencer side; the master modport is the decoder/bench side.
interface arith_sequencer_if #(
    parameter int NUM_PE        = 4,
    parameter int BEATS_PER_REG = 4,
    parameter int VL_W          = 8
) ();
    localparam int AW = 5 + $clog2(BEATS_PER_REG);

    // Handshake: an instruction transfers on a clock edge where instr_valid_i and
    // instr_ready_o are both high; the decoder holds valid and fields stable until then.
    logic              instr_valid_i;
    logic              instr_ready_o;
    logic [3:0]        arith_op_i;
    logic [1:0]        out_mode_i;
    logic [1:0]        sat_mode_i;
    logic [1:0]        operand_i;
    logic [1:0]        wb_src_i;
    logic [4:0]        vd_i;
    logic [4:0]        vs1_i;
    logic [4:0]        vs2_i;
    logic [VL_W-1:0]   vl_i;
    logic              stall_i;

    logic [3:0]        pe_op_o;
    logic [1:0]        pe_mode_o;
    logic [1:0]        pe_sat_o;
    logic [1:0]        pe_operand_o;
    logic [1:0]        wb_src_o;
    logic              vs1_rd_en_o;
    logic              vs2_rd_en_o;
    logic [AW-1:0]     vs1_addr_o;
    logic [AW-1:0]     vs2_addr_o;
    logic [NUM_PE-1:0] lane_en_o;
    logic              acc_first_o;
    logic              wb_en_o;
    logic [AW-1:0]     wb_addr_o;
    logic [NUM_PE-1:0] wb_lane_en_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output instr_valid_i, arith_op_i, out_mode_i, sat_mode_i, operand_i, wb_src_i,
               vd_i, vs1_i, vs2_i, vl_i, stall_i,
        input  instr_ready_o, pe_op_o, pe_mode_o, pe_sat_o, pe_operand_o, wb_src_o,
               vs1_rd_en_o, vs2_rd_en_o, vs1_addr_o, vs2_addr_o, lane_en_o, acc_first_o,
               wb_en_o, wb_addr_o, wb_lane_en_o, busy_o, done_o
    );

    modport slave (
        input  instr_valid_i, arith_op_i, out_mode_i, sat_mode_i, operand_i, wb_src_i,
               vd_i, vs1_i, vs2_i, vl_i, stall_i,
        output instr_ready_o, pe_op_o, pe_mode_o, pe_sat_o, pe_operand_o, wb_src_o,
               vs1_rd_en_o, vs2_rd_en_o, vs1_addr_o, vs2_addr_o, lane_en_o, acc_first_o,
               wb_en_o, wb_addr_o, wb_lane_en_o, busy_o, done_o
    );
endinterface

// File: rtl/arith_sequencer.sv
// Sequences one OP-V arithmetic instruction across the PE array, one beat per cycle,
// tracking each beat through the PE pipeline to generate vd write-backs.
module arith_sequencer #(
    parameter int NUM_PE        = 4,
    parameter int BEATS_PER_REG = 4,
    parameter int VL_W          = 8,
    parameter int PIPE_LAT      = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    arith_sequencer_if.slave bus,
    output logic [1:0]       dbg_state
);
    localparam int BEAT_W = $clog2(BEATS_PER_REG);
    localparam int AW     = 5 + BEAT_W;
    localparam logic [1:0] PE_OPERAND_VS1    = 2'd0;
    localparam logic [1:0] PE_OPERAND_RIPPLE = 2'd3;
    // Tracker stages that will still hold an entry after the next shift.
    localparam logic [PIPE_LAT-1:0] LOW_MASK = {PIPE_LAT{1'b1}} >> 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [3:0]      op_q;
    logic [1:0]      mode_q, sat_q, operand_q, wb_src_q;
    logic [4:0]      vd_q, vs1_q, vs2_q;
    logic [VL_W-1:0] beat_q, last_beat_q, rem_q;

    logic [PIPE_LAT-1:0] trk_valid, trk_last;
    logic [VL_W-1:0]     trk_beat [PIPE_LAT];
    logic [NUM_PE-1:0]   trk_lane [PIPE_LAT];

    logic              issue, is_last, ripple;
    logic [NUM_PE-1:0] lane_issue;
    logic [VL_W:0]     nbeats;

    assign issue     = (state_q == ISSUE) && !bus.stall_i;
    assign is_last   = (beat_q == last_beat_q);
    assign ripple    = (operand_q == PE_OPERAND_RIPPLE);
    assign dbg_state = state_q;

    always_comb begin
        nbeats = ({1'b0, bus.vl_i} + (VL_W+1)'(NUM_PE - 1)) / (VL_W+1)'(NUM_PE);
        for (int i = 0; i < NUM_PE; i++)
            lane_issue[i] = !(is_last && (rem_q != '0)) || (i < int'(rem_q));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_q        <= '0;
            mode_q      <= '0;
            sat_q       <= '0;
            operand_q   <= '0;
            wb_src_q    <= '0;
            vd_q        <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
            rem_q       <= '0;
            trk_valid   <= '0;
            trk_last    <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                trk_beat[i] <= '0;
                trk_lane[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.instr_valid_i) begin
                op_q        <= bus.arith_op_i;
                mode_q      <= bus.out_mode_i;
                sat_q       <= bus.sat_mode_i;
                operand_q   <= bus.operand_i;
                wb_src_q    <= bus.wb_src_i;
                vd_q        <= bus.vd_i;
                vs1_q       <= bus.vs1_i;
                vs2_q       <= bus.vs2_i;
                beat_q      <= '0;
                last_beat_q <= VL_W'(nbeats - (VL_W+1)'(1));
                rem_q       <= bus.vl_i % VL_W'(NUM_PE);
            end else if (issue) begin
                beat_q <= beat_q + VL_W'(1);
            end
            // Shifts every cycle; a stalled cycle enters as an empty slot.
            trk_valid[0] <= issue;
            trk_last[0]  <= issue && is_last;
            trk_beat[0]  <= beat_q;
            trk_lane[0]  <= lane_issue;
            for (int i = 1; i < PIPE_LAT; i++) begin
                trk_valid[i] <= trk_valid[i-1];
                trk_last[i]  <= trk_last[i-1];
                trk_beat[i]  <= trk_beat[i-1];
                trk_lane[i]  <= trk_lane[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.instr_valid_i) state_d = (bus.vl_i == '0) ? DONE : ISSUE;
            ISSUE: if (issue && is_last) state_d = DRAIN;
            DRAIN: if ((trk_valid & LOW_MASK) == '0) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.instr_ready_o = (state_q == IDLE);
        bus.busy_o        = (state_q != IDLE);
        bus.done_o        = (state_q == DONE);
        bus.pe_op_o       = op_q;
        bus.pe_mode_o     = mode_q;
        bus.pe_sat_o      = sat_q;
        bus.pe_operand_o  = operand_q;
        bus.wb_src_o      = wb_src_q;
        bus.vs2_rd_en_o   = issue;
        bus.vs1_rd_en_o   = issue && (operand_q == PE_OPERAND_VS1);
        bus.vs1_addr_o    = '0;
        bus.vs2_addr_o    = '0;
        bus.lane_en_o     = '0;
        bus.acc_first_o   = issue && (beat_q == '0);
        bus.wb_en_o       = '0;
        bus.wb_addr_o     = '0;
        bus.wb_lane_en_o  = '0;
        if (issue) begin
            bus.vs1_addr_o = AW'(32'(vs1_q) * BEATS_PER_REG + 32'(beat_q));
            bus.vs2_addr_o = AW'(32'(vs2_q) * BEATS_PER_REG + 32'(beat_q));
            bus.lane_en_o  = lane_issue;
        end
        // Ripple reductions accumulate across beats; only the final lane-0 result lands in vd.
        if (trk_valid[PIPE_LAT-1] && (!ripple || trk_last[PIPE_LAT-1])) begin
            bus.wb_en_o = 1'b1;
            if (ripple) begin
                bus.wb_addr_o    = AW'(32'(vd_q) * BEATS_PER_REG);
                bus.wb_lane_en_o = NUM_PE'(1);
            end else begin
                bus.wb_addr_o    = AW'(32'(vd_q) * BEATS_PER_REG + 32'(trk_beat[PIPE_LAT-1]));
                bus.wb_lane_en_o = trk_lane[PIPE_LAT-1];
            end
        end
    end
endmodule

// File: tb/tb_arith_sequencer.sv
// Directed bench for arith_sequencer: per-cycle comparison against a schedule model,
// plus literal pins on done cycle and write-back addresses for each scenario.
module tb_arith_sequencer;
    localparam int NUM_PE = 4;
    localparam int BPR    = 4;
    localparam int VL_W   = 8;
    localparam int LAT    = 2;
    localparam int AW     = 7;
    localparam int MAXC   = 64;
    localparam logic [1:0] OPND_VS1    = 2'd0;
    localparam logic [1:0] OPND_SCALAR = 2'd1;
    localparam logic [1:0] OPND_RIPPLE = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    arith_sequencer_if #(.NUM_PE(NUM_PE), .BEATS_PER_REG(BPR), .VL_W(VL_W)) bus ();
    arith_sequencer #(.NUM_PE(NUM_PE), .BEATS_PER_REG(BPR), .VL_W(VL_W), .PIPE_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .dbg_state(dbg_state)
    );

    int errors = 0;
    int checks = 0;

    logic          e_rd1 [MAXC], e_rd2 [MAXC], e_acc [MAXC], e_wb [MAXC], e_done [MAXC], e_busy [MAXC];
    logic [AW-1:0] e_a1 [MAXC], e_a2 [MAXC], e_wa [MAXC];
    logic [3:0]    e_ln [MAXC], e_wl [MAXC];
    int            exp_done_cyc;
    logic [3:0]    exp_op;
    logic [1:0]    exp_mode, exp_sat, exp_opnd, exp_wbs;

    logic          chk_en = 1'b0;
    int            cyc = 0;
    int            done_seen;
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] wb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Schedule model: beats issue on each non-stalled cycle from cycle 1, results land LAT later.
    task automatic build_model(input int vl, input logic [1:0] opnd, input int vd, input int vs1,
                               input int vs2, input logic [MAXC-1:0] stall_mask);
        int nb, t, k, last_t;
        for (int c = 0; c < MAXC; c++) begin
            e_rd1[c] = 0; e_rd2[c] = 0; e_acc[c] = 0; e_wb[c] = 0; e_done[c] = 0; e_busy[c] = 0;
            e_a1[c] = '0; e_a2[c] = '0; e_wa[c] = '0; e_ln[c] = '0; e_wl[c] = '0;
        end
        nb = (vl + NUM_PE - 1) / NUM_PE;
        t = 1; k = 0; last_t = 0;
        while (k < nb) begin
            if (!stall_mask[t]) begin
                e_rd2[t] = 1;
                e_rd1[t] = (opnd == OPND_VS1);
                e_a1[t]  = AW'(vs1 * BPR + k);
                e_a2[t]  = AW'(vs2 * BPR + k);
                e_ln[t]  = (k == nb - 1 && vl % NUM_PE != 0) ? 4'((1 << (vl % NUM_PE)) - 1) : 4'hF;
                e_acc[t] = (k == 0);
                if (opnd != OPND_RIPPLE) begin
                    e_wb[t+LAT] = 1; e_wa[t+LAT] = AW'(vd * BPR + k); e_wl[t+LAT] = e_ln[t];
                end else if (k == nb - 1) begin
                    e_wb[t+LAT] = 1; e_wa[t+LAT] = AW'(vd * BPR); e_wl[t+LAT] = 4'b0001;
                end
                last_t = t;
                k++;
            end
            t++;
        end
        exp_done_cyc = (vl == 0) ? 1 : last_t + LAT + 1;
        for (int c = 1; c <= exp_done_cyc; c++) e_busy[c] = 1;
        e_done[exp_done_cyc] = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("instr_ready", 32'(bus.instr_ready_o), 32'(!e_busy[cyc]));
            chk("busy", 32'(bus.busy_o), 32'(e_busy[cyc]));
            chk("done", 32'(bus.done_o), 32'(e_done[cyc]));
            chk("vs1_rd_en", 32'(bus.vs1_rd_en_o), 32'(e_rd1[cyc]));
            chk("vs2_rd_en", 32'(bus.vs2_rd_en_o), 32'(e_rd2[cyc]));
            chk("lane_en", 32'(bus.lane_en_o), 32'(e_ln[cyc]));
            chk("acc_first", 32'(bus.acc_first_o), 32'(e_acc[cyc]));
            chk("wb_en", 32'(bus.wb_en_o), 32'(e_wb[cyc]));
            if (e_rd1[cyc]) chk("vs1_addr", 32'(bus.vs1_addr_o), 32'(e_a1[cyc]));
            if (e_rd2[cyc]) chk("vs2_addr", 32'(bus.vs2_addr_o), 32'(e_a2[cyc]));
            if (e_wb[cyc]) begin
                chk("wb_addr", 32'(bus.wb_addr_o), 32'(e_wa[cyc]));
                chk("wb_lane_en", 32'(bus.wb_lane_en_o), 32'(e_wl[cyc]));
            end
            if (cyc >= 1) begin
                chk("pe_op", 32'(bus.pe_op_o), 32'(exp_op));
                chk("pe_mode", 32'(bus.pe_mode_o), 32'(exp_mode));
                chk("pe_sat", 32'(bus.pe_sat_o), 32'(exp_sat));
                chk("pe_operand", 32'(bus.pe_operand_o), 32'(exp_opnd));
                chk("wb_src", 32'(bus.wb_src_o), 32'(exp_wbs));
            end
            if (bus.done_o && done_seen < 0) done_seen = cyc;
            if (bus.wb_en_o) wb_q.push_back(bus.wb_addr_o);
        end
    end

    // Called #1 after a rising edge with the DUT idle; returns at the same phase.
    task automatic run(input int vl, input logic [3:0] op, input logic [1:0] mode, input logic [1:0] sat,
                       input logic [1:0] opnd, input logic [1:0] wbs, input int vd, input int vs1,
                       input int vs2, input logic [MAXC-1:0] stall_mask, input bit hold_valid);
        build_model(vl, opnd, vd, vs1, vs2, stall_mask);
        wb_q.delete();
        done_seen = -1;
        bus.arith_op_i = op;   bus.out_mode_i = mode; bus.sat_mode_i = sat;
        bus.operand_i = opnd;  bus.wb_src_i = wbs;
        bus.vd_i = 5'(vd);     bus.vs1_i = 5'(vs1);   bus.vs2_i = 5'(vs2);
        bus.vl_i = VL_W'(vl);  bus.instr_valid_i = 1'b1; bus.stall_i = 1'b0;
        cyc = 0;
        chk_en = 1'b1;
        for (int c = 1; c <= exp_done_cyc + 1; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            if (c == 1) begin
                exp_op = op; exp_mode = mode; exp_sat = sat; exp_opnd = opnd; exp_wbs = wbs;
            end
            bus.stall_i = stall_mask[c];
            // Busy-time requests carry different fields and must be ignored.
            bus.instr_valid_i = hold_valid && (c <= exp_done_cyc);
            if (hold_valid) begin
                bus.arith_op_i = ~op; bus.operand_i = ~opnd; bus.vd_i = ~5'(vd);
                bus.vs2_i = ~5'(vs2); bus.vl_i = ~VL_W'(vl);
            end
        end
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        bus.instr_valid_i = 1'b0;
        bus.stall_i = 1'b0;
    endtask

    task automatic chk_wb_list(input string name);
        chk({name, "_wb_count"}, 32'(wb_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wb_q.size(); i++)
            chk({name, "_wb_addr"}, 32'(wb_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        rst = 1'b1;
        bus.instr_valid_i = 1'b0; bus.stall_i = 1'b0;
        bus.arith_op_i = '0; bus.out_mode_i = '0; bus.sat_mode_i = '0; bus.operand_i = '0;
        bus.wb_src_i = '0; bus.vd_i = '0; bus.vs1_i = '0; bus.vs2_i = '0; bus.vl_i = '0;
        exp_op = '0; exp_mode = '0; exp_sat = '0; exp_opnd = '0; exp_wbs = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(bus.instr_ready_o), 32'd1);
        chk("reset_busy", 32'(bus.busy_o), 32'd0);
        chk("reset_wb_en", 32'(bus.wb_en_o), 32'd0);
        chk("reset_rd_en", 32'({bus.vs1_rd_en_o, bus.vs2_rd_en_o}), 32'd0);
        chk("reset_cfg", 32'({bus.pe_op_o, bus.pe_mode_o, bus.pe_sat_o, bus.pe_operand_o, bus.wb_src_o}), 32'd0);
        @(posedge clk);
        #1;

        run(16, 4'd3, 2'd1, 2'd2, OPND_VS1, 2'd0, 8, 2, 4, '0, 1'b0);
        chk("vl16_done_cycle", 32'(done_seen), 32'd7);
        exp_q = '{7'd32, 7'd33, 7'd34, 7'd35};
        chk_wb_list("vl16");

        run(6, 4'd1, 2'd0, 2'd1, OPND_SCALAR, 2'd0, 1, 3, 5, '0, 1'b0);
        chk("vl6_done_cycle", 32'(done_seen), 32'd5);
        exp_q = '{7'd4, 7'd5};
        chk_wb_list("vl6");

        run(10, 4'd2, 2'd2, 2'd0, OPND_RIPPLE, 2'd0, 5, 6, 7, '0, 1'b0);
        chk("ripple_done_cycle", 32'(done_seen), 32'd6);
        exp_q = '{7'd20};
        chk_wb_list("ripple");

        run(8, 4'd4, 2'd0, 2'd0, OPND_VS1, 2'd0, 2, 1, 3, 64'b1100, 1'b0);
        chk("stall_done_cycle", 32'(done_seen), 32'd7);
        exp_q = '{7'd8, 7'd9};
        chk_wb_list("stall");

        run(0, 4'd5, 2'd1, 2'd1, OPND_VS1, 2'd1, 9, 9, 9, '0, 1'b0);
        chk("vl0_done_cycle", 32'(done_seen), 32'd1);
        exp_q.delete();
        chk_wb_list("vl0");

        run(20, 4'd6, 2'd3, 2'd3, OPND_VS1, 2'd0, 31, 31, 31, 64'b100000, 1'b1);
        chk("wrap_done_cycle", 32'(done_seen), 32'd9);
        exp_q = '{7'd124, 7'd125, 7'd126, 7'd127, 7'd0};
        chk_wb_list("wrap");

        run(3, 4'd7, 2'd0, 2'd2, OPND_RIPPLE, 2'd0, 12, 4, 10, '0, 1'b0);
        chk("ripple1_done_cycle", 32'(done_seen), 32'd4);
        exp_q = '{7'd48};
        chk_wb_list("ripple1");

        // Abort during ISSUE: outputs clear immediately, no write-back after release.
        bus.arith_op_i = 4'd9; bus.operand_i = OPND_VS1; bus.vd_i = 5'd3;
        bus.vs1_i = 5'd1; bus.vs2_i = 5'd2; bus.vl_i = 8'd16; bus.instr_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.instr_ready_o), 32'd1);
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_lane_en", 32'(bus.lane_en_o), 32'd0);
        chk("abort_rd_en", 32'({bus.vs1_rd_en_o, bus.vs2_rd_en_o}), 32'd0);
        chk("abort_pe_op", 32'(bus.pe_op_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_wb", 32'(bus.wb_en_o), 32'd0);
            chk("abort_idle", 32'(bus.busy_o), 32'd0);
        end
        @(posedge clk);
        #1;

        run(7, 4'd8, 2'd1, 2'd0, OPND_VS1, 2'd0, 30, 0, 1, '0, 1'b0);
        chk("post_reset_done_cycle", 32'(done_seen), 32'd5);
        exp_q = '{7'd120, 7'd121};
        chk_wb_list("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete, errors=%0d", errors + 1);
        $fatal(1, "timeout");
    end
endmodule
